// File: rtl/wb_arb_intercon.sv
// wb_arb_intercon: two-master Wishbone arbiter with address decode and bus-error/timeout termination
module wb_arb_intercon #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SLAVES = 4,
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_ADDR = {(NUM_SLAVES*32){1'b1}},
   parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0,
   parameter int TIMEOUT = 255
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [31:0]                   wbm0_adr_i,
   input  logic [DATA_WIDTH-1:0]         wbm0_dat_i,
   input  logic [DATA_WIDTH/8-1:0]       wbm0_sel_i,
   input  logic                          wbm0_we_i,
   input  logic                          wbm0_cyc_i,
   input  logic                          wbm0_stb_i,
   output logic [DATA_WIDTH-1:0]         wbm0_dat_o,
   output logic                          wbm0_ack_o,
   output logic                          wbm0_err_o,
   input  logic [31:0]                   wbm1_adr_i,
   input  logic [DATA_WIDTH-1:0]         wbm1_dat_i,
   input  logic [DATA_WIDTH/8-1:0]       wbm1_sel_i,
   input  logic                          wbm1_we_i,
   input  logic                          wbm1_cyc_i,
   input  logic                          wbm1_stb_i,
   output logic [DATA_WIDTH-1:0]         wbm1_dat_o,
   output logic                          wbm1_ack_o,
   output logic                          wbm1_err_o,
   output logic [31:0]                   wbs_adr_o,
   output logic [DATA_WIDTH-1:0]         wbs_dat_o,
   output logic [DATA_WIDTH/8-1:0]       wbs_sel_o,
   output logic                          wbs_we_o,
   output logic [NUM_SLAVES-1:0]         wbs_cyc_o,
   output logic [NUM_SLAVES-1:0]         wbs_stb_o,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i,
   input  logic [NUM_SLAVES-1:0]         wbs_ack_i
);
   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
   state_t state, state_n;
   logic grant, grant_n, last, last_n;
   logic [15:0] cnt, cnt_n;
   logic req0, req1, gcyc, gstb, hit, sack, busy, ack, to;
   logic [NUM_SLAVES-1:0] dec;
   logic [DATA_WIDTH-1:0] sdat, rdat;
   assign req0 = wbm0_cyc_i & wbm0_stb_i;
   assign req1 = wbm1_cyc_i & wbm1_stb_i;
   assign gcyc = grant ? wbm1_cyc_i : wbm0_cyc_i;
   assign gstb = grant ? wbm1_stb_i : wbm0_stb_i;
   assign wbs_adr_o = grant ? wbm1_adr_i : wbm0_adr_i;
   assign wbs_dat_o = grant ? wbm1_dat_i : wbm0_dat_i;
   assign wbs_sel_o = grant ? wbm1_sel_i : wbm0_sel_i;
   assign wbs_we_o = grant ? wbm1_we_i : wbm0_we_i;
   // descending scan so the lowest matching index is the one left standing
   always_comb begin
      dec = '0;
      hit = 1'b0;
      sack = 1'b0;
      sdat = '0;
      for (int k = NUM_SLAVES - 1; k >= 0; k--)
         if ((wbs_adr_o & SLAVE_MASK[k*32 +: 32]) == (SLAVE_ADDR[k*32 +: 32] & SLAVE_MASK[k*32 +: 32])) begin
            dec = '0;
            dec[k] = 1'b1;
            hit = 1'b1;
            sack = wbs_ack_i[k];
            sdat = wbs_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
         end
   end
   assign busy = (state == BUSY) & gcyc & hit;
   assign ack = busy & gstb & sack;
   // an ack in the last allowed cycle wins over the timeout
   assign to = busy & gstb & ~sack & (cnt == 16'(TIMEOUT - 1));
   assign wbs_cyc_o = busy ? dec : '0;
   assign wbs_stb_o = (busy & gstb) ? dec : '0;
   assign rdat = busy ? sdat : '0;
   assign wbm0_ack_o = ack & ~grant;
   assign wbm1_ack_o = ack & grant;
   assign wbm0_err_o = (state == ERR) & ~grant;
   assign wbm1_err_o = (state == ERR) & grant;
   assign wbm0_dat_o = grant ? '0 : rdat;
   assign wbm1_dat_o = grant ? rdat : '0;
   always_comb begin
      state_n = state;
      grant_n = grant;
      last_n = last;
      cnt_n = '0;
      case (state)
         IDLE: if (req0 | req1) begin
            state_n = BUSY;
            grant_n = (req0 & req1) ? ~last : req1;
         end
         BUSY: if (!gcyc) begin
            state_n = IDLE;
            last_n = grant;
         end else if (gstb & (~hit | to)) state_n = ERR;
         else if (gstb & ~ack) cnt_n = cnt + 16'd1;
         default: begin
            state_n = gcyc ? BUSY : IDLE;
            last_n = gcyc ? last : grant;
         end
      endcase
   end
   always_ff @(posedge clk_i)
      if (!rst_i) begin
         state <= IDLE;
         grant <= 1'b0;
         last <= 1'b1;
         cnt <= '0;
      end else begin
         state <= state_n;
         grant <= grant_n;
         last <= last_n;
         cnt <= cnt_n;
      end
endmodule

// File: tb/tb_wb_arb_intercon.sv
// tb_wb_arb_intercon: directed vector table, corner sequences and random traffic against a transaction-level model
module tb_wb_arb_intercon;
   localparam int DW = 32, NS = 4, TO = 8;
   localparam logic [31:0] A0 = 32'h1004, A1 = 32'h2008, A2 = 32'h40, NM = 32'h8000_0000;
   localparam logic [31:0] S0 = 32'hDEADBEEF, S1 = 32'h11112222, S2 = 32'h33334444, S3 = 32'h55556666;
   logic clk_i = 1'b0, rst_i = 1'b0;
   logic [31:0] wbm0_adr_i, wbm1_adr_i, wbs_adr_o;
   logic [DW-1:0] wbm0_dat_i, wbm1_dat_i, wbm0_dat_o, wbm1_dat_o, wbs_dat_o;
   logic [DW/8-1:0] wbm0_sel_i, wbm1_sel_i, wbs_sel_o;
   logic wbm0_we_i, wbm0_cyc_i, wbm0_stb_i, wbm1_we_i, wbm1_cyc_i, wbm1_stb_i;
   logic wbm0_ack_o, wbm0_err_o, wbm1_ack_o, wbm1_err_o, wbs_we_o;
   logic [NS-1:0] wbs_cyc_o, wbs_stb_o, wbs_ack_i;
   logic [NS*DW-1:0] wbs_dat_i;
   int checks = 0, errors = 0;
   always #5 clk_i = ~clk_i;
   wb_arb_intercon #(
      .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT(TO),
      .SLAVE_ADDR({32'h4ABC_DEF0, 32'h0000_0000, 32'h0000_2000, 32'h0000_1000}),
      .SLAVE_MASK({32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000})
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .wbm0_adr_i(wbm0_adr_i), .wbm0_dat_i(wbm0_dat_i), .wbm0_sel_i(wbm0_sel_i), .wbm0_we_i(wbm0_we_i),
      .wbm0_cyc_i(wbm0_cyc_i), .wbm0_stb_i(wbm0_stb_i), .wbm0_dat_o(wbm0_dat_o), .wbm0_ack_o(wbm0_ack_o),
      .wbm0_err_o(wbm0_err_o),
      .wbm1_adr_i(wbm1_adr_i), .wbm1_dat_i(wbm1_dat_i), .wbm1_sel_i(wbm1_sel_i), .wbm1_we_i(wbm1_we_i),
      .wbm1_cyc_i(wbm1_cyc_i), .wbm1_stb_i(wbm1_stb_i), .wbm1_dat_o(wbm1_dat_o), .wbm1_ack_o(wbm1_ack_o),
      .wbm1_err_o(wbm1_err_o),
      .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
      .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i)
   );
   typedef struct {
      logic rst, c0, s0, c1, s1, xa0, xe0, xa1, xe1;
      logic [31:0] a0, a1, xd0, xd1;
      logic [3:0] ack, xcyc, xstb;
   } vec_t;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
      end
   endtask
   function automatic vec_t mk(input int r, c0, s0, a0, c1, s1, a1, ack, xc, xs, xa0, xe0, xa1, xe1, xd0, xd1);
      vec_t v;
      v.rst = r[0]; v.c0 = c0[0]; v.s0 = s0[0]; v.a0 = a0; v.c1 = c1[0]; v.s1 = s1[0]; v.a1 = a1;
      v.ack = ack[3:0]; v.xcyc = xc[3:0]; v.xstb = xs[3:0];
      v.xa0 = xa0[0]; v.xe0 = xe0[0]; v.xa1 = xa1[0]; v.xe1 = xe1[0]; v.xd0 = xd0; v.xd1 = xd1;
      return v;
   endfunction
   task automatic apply(input vec_t v);
      @(negedge clk_i);
      rst_i = v.rst;
      wbm0_cyc_i = v.c0; wbm0_stb_i = v.s0; wbm0_adr_i = v.a0;
      wbm1_cyc_i = v.c1; wbm1_stb_i = v.s1; wbm1_adr_i = v.a1;
      wbs_ack_i = v.ack;
      #1;
      chk("cyc", 32'(wbs_cyc_o), 32'(v.xcyc));
      chk("stb", 32'(wbs_stb_o), 32'(v.xstb));
      chk("ack0", 32'(wbm0_ack_o), 32'(v.xa0));
      chk("err0", 32'(wbm0_err_o), 32'(v.xe0));
      chk("ack1", 32'(wbm1_ack_o), 32'(v.xa1));
      chk("err1", 32'(wbm1_err_o), 32'(v.xe1));
      chk("dat0", wbm0_dat_o, v.xd0);
      chk("dat1", wbm1_dat_o, v.xd1);
   endtask
   function automatic int decode(input logic [31:0] a);
      if ((a & 32'hFFFF_F000) == 32'h1000) return 0;
      if ((a & 32'hFFFF_F000) == 32'h2000) return 1;
      if ((a & 32'hFFFF_0000) == 32'h0) return 2;
      if ((a & 32'hF000_0000) == 32'h4000_0000) return 3;
      return -1;
   endfunction
   function automatic logic [31:0] pick_adr();
      case ($urandom_range(6))
         0: return A0;
         1: return A1;
         2: return 32'($urandom_range(16'hFFFF));
         3: return 32'h4123_4560;
         4: return NM;
         5: return 32'hFFFF_0000;
         default: return $urandom;
      endcase
   endfunction
   vec_t tbl[25];
   int own, turn, wt, k;
   bit merr;
   logic c[2], s[2];
   logic [31:0] a[2], xd[2];
   logic [1:0] xa, xe;
   logic [3:0] xc, xs;
   initial begin
      wbm0_adr_i = 0; wbm1_adr_i = 0; wbm0_dat_i = 0; wbm1_dat_i = 0; wbm0_sel_i = 0; wbm1_sel_i = 0;
      wbm0_we_i = 0; wbm1_we_i = 0; wbm0_cyc_i = 0; wbm0_stb_i = 0; wbm1_cyc_i = 0; wbm1_stb_i = 0;
      wbs_ack_i = 0; wbs_dat_i = {S3, S2, S1, S0};
      repeat (2) @(posedge clk_i);
      tbl[0]  = mk(0, 1,1,A0, 1,1,A1, 15, 0,0, 0,0,0,0, 0,0);
      tbl[1]  = mk(1, 1,1,A0, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[2]  = mk(1, 1,1,A0, 1,1,A1, 1,  1,1, 1,0,0,0, S0,0);
      tbl[3]  = mk(1, 0,0,A0, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[4]  = mk(1, 0,0,A0, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[5]  = mk(1, 0,0,A0, 1,1,A1, 2,  2,2, 0,0,1,0, 0,S1);
      tbl[6]  = mk(1, 0,0,A0, 0,0,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[7]  = mk(1, 1,1,A0, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[8]  = mk(1, 1,1,A0, 1,1,A1, 2,  1,1, 0,0,0,0, S0,0);
      tbl[9]  = mk(1, 1,1,A0, 1,1,A1, 1,  1,1, 1,0,0,0, S0,0);
      tbl[10] = mk(1, 0,0,A0, 0,0,NM, 0,  0,0, 0,0,0,0, 0,0);
      tbl[11] = mk(1, 0,0,A0, 1,1,NM, 15, 0,0, 0,0,0,0, 0,0);
      tbl[12] = mk(1, 0,0,A0, 1,1,NM, 15, 0,0, 0,0,0,0, 0,0);
      tbl[13] = mk(1, 0,0,A0, 1,0,NM, 15, 0,0, 0,0,0,1, 0,0);
      tbl[14] = mk(1, 0,0,A0, 1,0,NM, 15, 0,0, 0,0,0,0, 0,0);
      tbl[15] = mk(1, 0,0,A0, 0,0,NM, 0,  0,0, 0,0,0,0, 0,0);
      tbl[16] = mk(1, 1,1,A0, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[17] = mk(1, 1,1,A0, 1,1,A1, 1,  1,1, 1,0,0,0, S0,0);
      tbl[18] = mk(1, 1,0,A0, 1,1,A1, 0,  1,0, 0,0,0,0, S0,0);
      tbl[19] = mk(1, 1,1,A1, 1,1,A1, 2,  2,2, 1,0,0,0, S1,0);
      tbl[20] = mk(1, 1,1,A2, 1,1,A1, 4,  4,4, 1,0,0,0, S2,0);
      tbl[21] = mk(1, 0,0,A2, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[22] = mk(1, 0,0,A2, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0);
      tbl[23] = mk(1, 0,0,A2, 1,1,A1, 2,  2,2, 0,0,1,0, 0,S1);
      tbl[24] = mk(1, 0,0,A2, 0,0,A1, 0,  0,0, 0,0,0,0, 0,0);
      for (int i = 0; i < 25; i++) apply(tbl[i]);
      // timeout: eight forwarded strobe cycles, then a one-cycle error
      apply(mk(1, 1,1,A1, 0,0,0, 0, 0,0, 0,0,0,0, 0,0));
      for (int i = 0; i < TO; i++) apply(mk(1, 1,1,A1, 0,0,0, 0, 2,2, 0,0,0,0, S1,0));
      apply(mk(1, 1,0,A1, 0,0,0, 0, 0,0, 0,1,0,0, 0,0));
      apply(mk(1, 1,0,A1, 0,0,0, 0, 2,0, 0,0,0,0, S1,0));
      for (int i = 0; i < TO - 1; i++) apply(mk(1, 1,1,A1, 0,0,0, 0, 2,2, 0,0,0,0, S1,0));
      apply(mk(1, 1,1,A1, 0,0,0, 2, 2,2, 1,0,0,0, S1,0));
      apply(mk(1, 1,1,A1, 0,0,0, 0, 2,2, 0,0,0,0, S1,0));
      apply(mk(1, 0,0,A1, 0,0,0, 0, 0,0, 0,0,0,0, 0,0));
      // reset during an m1 transfer, after m0 was the last owner
      apply(mk(1, 0,0,A0, 1,1,A1, 0,  0,0, 0,0,0,0, 0,0));
      apply(mk(1, 0,0,A0, 1,1,A1, 0,  2,2, 0,0,0,0, 0,S1));
      apply(mk(0, 1,1,A0, 1,1,A1, 15, 2,2, 0,0,1,0, 0,S1));
      apply(mk(1, 1,1,A0, 1,1,A1, 15, 0,0, 0,0,0,0, 0,0));
      apply(mk(1, 1,1,A0, 1,1,A1, 1,  1,1, 1,0,0,0, S0,0));
      apply(mk(1, 0,0,A0, 0,0,A1, 0,  0,0, 0,0,0,0, 0,0));
      own = -1; turn = 0; wt = 0; merr = 0; k = -1;
      c = '{0, 0}; s = '{0, 0}; a = '{A0, A1};
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk_i);
         rst_i = !(n == 0 || $urandom_range(99) == 0);
         for (int m = 0; m < 2; m++) begin
            if ($urandom_range(7) == 0) c[m] = ~c[m];
            if ($urandom_range(3) == 0) s[m] = 1'($urandom_range(1));
            if ($urandom_range(5) == 0) a[m] = pick_adr();
         end
         wbm0_cyc_i = c[0]; wbm0_stb_i = s[0]; wbm0_adr_i = a[0];
         wbm1_cyc_i = c[1]; wbm1_stb_i = s[1]; wbm1_adr_i = a[1];
         wbm0_dat_i = $urandom; wbm1_dat_i = $urandom; wbm0_sel_i = 4'($urandom); wbm1_sel_i = 4'($urandom);
         wbm0_we_i = 1'($urandom_range(1)); wbm1_we_i = 1'($urandom_range(1));
         for (int j = 0; j < NS; j++) wbs_ack_i[j] = ($urandom_range(4) == 0);
         wbs_dat_i = {$urandom, $urandom, $urandom, $urandom};
         #1;
         xc = 0; xs = 0; xa = 0; xe = 0; xd = '{0, 0};
         if (own >= 0) begin
            k = decode(a[own]);
            if (merr) xe[own] = 1'b1;
            else if (c[own] && k >= 0) begin
               xc = 4'(1 << k);
               xs = s[own] ? 4'(1 << k) : 4'd0;
               xd[own] = wbs_dat_i[k*32 +: 32];
               xa[own] = s[own] & wbs_ack_i[k];
            end
            chk("r_adr", wbs_adr_o, a[own]);
            chk("r_we", 32'(wbs_we_o), 32'(own ? wbm1_we_i : wbm0_we_i));
         end
         chk("r_cyc", 32'(wbs_cyc_o), 32'(xc));
         chk("r_stb", 32'(wbs_stb_o), 32'(xs));
         chk("r_ack0", 32'(wbm0_ack_o), 32'(xa[0]));
         chk("r_ack1", 32'(wbm1_ack_o), 32'(xa[1]));
         chk("r_err0", 32'(wbm0_err_o), 32'(xe[0]));
         chk("r_err1", 32'(wbm1_err_o), 32'(xe[1]));
         chk("r_dat0", wbm0_dat_o, xd[0]);
         chk("r_dat1", wbm1_dat_o, xd[1]);
         if (!rst_i) begin
            own = -1; merr = 0; wt = 0; turn = 0;
         end else if (own < 0) begin
            if ((c[0] & s[0]) | (c[1] & s[1])) begin
               own = (c[0] & s[0] & c[1] & s[1]) ? turn : ((c[0] & s[0]) ? 0 : 1);
               wt = 0;
            end
         end else if (!c[own]) begin
            turn = 1 - own; own = -1; merr = 0; wt = 0;
         end else if (merr) begin
            merr = 0; wt = 0;
         end else if (s[own]) begin
            if (k < 0) merr = 1;
            else if (wbs_ack_i[k]) wt = 0;
            else if (wt + 1 == TO) begin
               merr = 1; wt = 0;
            end else wt++;
         end else wt = 0;
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
